// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: command encodings,
// sequencer states and default sizing.
package hilo_muldiv_unit_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_DIV_TIMEOUT = 40;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_LAUNCH,
        ST_DIV_WAIT,
        ST_DIV_FIX,
        ST_MUL_RUN,
        ST_COMMIT
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Command, result and divider-handshake bundle of the HI/LO unit; the unit
// itself takes the slave view, the control unit / divider side takes master.
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             div_err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_done;

    modport slave (
        input  start, op, a, b, div_q, div_r, div_done,
        output busy, done, div_zero, div_err, hi, lo, div_start, div_a, div_b
    );

    modport master (
        output start, op, a, b, div_q, div_r, div_done,
        input  busy, done, div_zero, div_err, hi, lo, div_start, div_a, div_b
    );

endinterface

// File: rtl/hilo_muldiv_unit_shift_add_mult.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// 2*WIDTH-bit accumulator, signed or unsigned operands.
module shift_add_mult
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic               running;
    logic               signed_q;
    logic               last_step;

    assign last_step = (count == CNT_W'(WIDTH - 1));
    assign product   = acc;

    // The top multiplier bit of a signed operand weighs -2^(WIDTH-1), so the
    // final partial product is subtracted instead of added.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            running  <= 1'b0;
            signed_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc      <= '0;
                mcand    <= is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                mplier   <= b;
                count    <= '0;
                running  <= 1'b1;
                signed_q <= is_signed;
            end else if (running) begin
                if (mplier[0]) begin
                    acc <= (signed_q && last_step) ? (acc - mcand) : (acc + mcand);
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (last_step) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair and sequencer: MTHI/MTLO writes, signed/unsigned divide
// around an external unsigned divider, and multiply through shift_add_mult.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DIV_TIMEOUT = DEFAULT_DIV_TIMEOUT
) (
    input logic               clock,
    input logic               reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > DIV_TIMEOUT) ? WIDTH : DIV_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   div_a_q;
    logic [WIDTH-1:0]   div_b_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               cmd_is_mul;
    logic               done_q;
    logic               div_zero_q;
    logic               div_err_q;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               accept;
    logic               mult_start;
    logic               mult_done;
    logic               wait_timeout;
    logic               mul_last;
    logic               neg_a;
    logic               neg_b;
    logic [2*WIDTH-1:0] product;

    assign accept       = (state == ST_IDLE) && bus.start;
    assign mult_start   = accept && is_mul_op(bus.op);
    assign wait_timeout = (cycle_cnt == CNT_W'(DIV_TIMEOUT - 1));
    assign mul_last     = (cycle_cnt == CNT_W'(WIDTH - 1));
    assign neg_a        = (bus.op == OP_DIV) && bus.a[WIDTH-1];
    assign neg_b        = (bus.op == OP_DIV) && bus.b[WIDTH-1];

    assign bus.busy      = (state != ST_IDLE);
    assign bus.div_start = (state == ST_DIV_LAUNCH);
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.div_err   = div_err_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;

    shift_add_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clock     (clock),
        .reset     (reset),
        .start     (mult_start),
        .is_signed (bus.op == OP_MULT),
        .a         (bus.a),
        .b         (bus.b),
        .product   (product),
        .done      (mult_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Divide-by-zero and register moves finish straight from IDLE; only real
    // MULT/DIV work walks through the busy states.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op(bus.op)) begin
                        next_state = ST_MUL_RUN;
                    end else if (is_div_op(bus.op) && (bus.b != '0)) begin
                        next_state = ST_DIV_LAUNCH;
                    end
                end
            end
            ST_DIV_LAUNCH: next_state = ST_DIV_WAIT;
            ST_DIV_WAIT: begin
                if (bus.div_done) begin
                    next_state = ST_DIV_FIX;
                end else if (wait_timeout) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DIV_FIX: next_state = ST_COMMIT;
            ST_MUL_RUN: begin
                if (mul_last) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            cmd_is_mul <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            div_err_q  <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        div_err_q <= 1'b0;
                        cycle_cnt <= '0;
                        case (bus.op)
                            OP_MTHI: begin
                                hi_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                cmd_is_mul <= 1'b0;
                                if (bus.b == '0) begin
                                    done_q     <= 1'b1;
                                    div_zero_q <= 1'b1;
                                end else begin
                                    // Magnitude of the most negative value wraps to itself,
                                    // which is the correct unsigned magnitude.
                                    sign_a_q <= neg_a;
                                    sign_b_q <= neg_b;
                                    div_a_q  <= neg_a ? -bus.a : bus.a;
                                    div_b_q  <= neg_b ? -bus.b : bus.b;
                                end
                            end
                            OP_MULT, OP_MULTU: cmd_is_mul <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_DIV_LAUNCH: cycle_cnt <= '0;
                ST_DIV_WAIT: begin
                    if (bus.div_done) begin
                        quo_q <= bus.div_q;
                        rem_q <= bus.div_r;
                    end else if (wait_timeout) begin
                        div_err_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_DIV_FIX: begin
                    if (sign_a_q ^ sign_b_q) begin
                        quo_q <= -quo_q;
                    end
                    if (sign_a_q) begin
                        rem_q <= -rem_q;
                    end
                end
                ST_MUL_RUN: cycle_cnt <= cycle_cnt + 1'b1;
                ST_COMMIT: begin
                    done_q <= 1'b1;
                    if (cmd_is_mul) begin
                        if (mult_done) begin
                            hi_q <= product[2*WIDTH-1:WIDTH];
                            lo_q <= product[WIDTH-1:0];
                        end
                    end else begin
                        hi_q <= rem_q;
                        lo_q <= quo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit with a stub unsigned
// divider and an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam int WIDTH       = 32;
    localparam int DIV_TIMEOUT = 40;

    logic clock;
    logic reset;

    hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_unit #(
        .WIDTH       (WIDTH),
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks_total;
    int          checks_passed;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    int          div_start_cnt;
    logic [31:0] seen_div_a;
    logic [31:0] seen_div_b;
    int          stub_delay;
    bit          stub_hang;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stub divider: answers stub_delay cycles after a launch, or never when hung.
    initial begin
        bus.div_done = 1'b0;
        bus.div_q    = '0;
        bus.div_r    = '0;
        forever begin
            @(negedge clock);
            if (bus.div_start) begin
                div_start_cnt++;
                seen_div_a = bus.div_a;
                seen_div_b = bus.div_b;
                if (!stub_hang) begin
                    repeat (stub_delay) @(negedge clock);
                    bus.div_q    = seen_div_a / seen_div_b;
                    bus.div_r    = seen_div_a % seen_div_b;
                    bus.div_done = 1'b1;
                    @(negedge clock);
                    bus.div_done = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op_in, input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] exp_hi, exp_lo, exp_ma, exp_mb;
        logic [63:0] prod, q64, r64, ma64, mb64;
        longint      sa, sb;
        bit          exp_done, exp_busy, exp_zero, exp_err, exp_launch, seen;
        int          exp_lat, limit, n, starts0;

        exp_hi = mdl_hi; exp_lo = mdl_lo; exp_ma = '0; exp_mb = '0;
        exp_done = 1'b1; exp_busy = 1'b0; exp_zero = 1'b0; exp_err = 1'b0; exp_launch = 1'b0;
        exp_lat = 1;
        sa = longint'($signed(a_in));
        sb = longint'($signed(b_in));
        case (op_in)
            OP_MTHI: exp_hi = a_in;
            OP_MTLO: exp_lo = a_in;
            OP_MULT, OP_MULTU: begin
                if (op_in == OP_MULT) prod = sa * sb;
                else                  prod = {32'b0, a_in} * {32'b0, b_in};
                exp_hi = prod[63:32]; exp_lo = prod[31:0];
                exp_busy = 1'b1; exp_lat = WIDTH + 2;
            end
            OP_DIV, OP_DIVU: begin
                if (b_in == 32'd0) begin
                    exp_zero = 1'b1;
                end else begin
                    exp_busy = 1'b1; exp_launch = 1'b1;
                    if (op_in == OP_DIV) begin
                        q64 = sa / sb; r64 = sa % sb;
                        ma64 = (sa < 0) ? -sa : sa; mb64 = (sb < 0) ? -sb : sb;
                    end else begin
                        q64 = {32'b0, a_in} / {32'b0, b_in}; r64 = {32'b0, a_in} % {32'b0, b_in};
                        ma64 = {32'b0, a_in}; mb64 = {32'b0, b_in};
                    end
                    exp_ma = ma64[31:0]; exp_mb = mb64[31:0];
                    if (stub_hang) begin
                        exp_err = 1'b1; exp_lat = DIV_TIMEOUT + 2;
                    end else begin
                        exp_lo = q64[31:0]; exp_hi = r64[31:0]; exp_lat = stub_delay + 4;
                    end
                end
            end
            default: exp_done = 1'b0;
        endcase

        starts0 = div_start_cnt;
        @(negedge clock);
        bus.start = 1'b1; bus.op = op_in; bus.a = a_in; bus.b = b_in;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        checkOutput("busy", bus.busy, exp_busy);
        limit = exp_done ? exp_lat + 8 : WIDTH + 8;
        n = 1;
        while (!bus.done && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        seen = bus.done;
        checkOutput("done_seen", seen, exp_done);
        if (seen) begin
            checkOutput("latency", n, exp_lat);
            checkOutput("div_zero", bus.div_zero, exp_zero);
            checkOutput("busy_at_done", bus.busy, 1'b0);
            @(posedge clock);
            #1;
            checkOutput("done_pulse", bus.done, 1'b0);
        end
        checkOutput("hi", bus.hi, exp_hi);
        checkOutput("lo", bus.lo, exp_lo);
        checkOutput("div_err", bus.div_err, exp_err);
        checkOutput("launches", div_start_cnt - starts0, exp_launch);
        if (exp_launch) begin
            checkOutput("div_a", seen_div_a, exp_ma);
            checkOutput("div_b", seen_div_b, exp_mb);
        end
        mdl_hi = exp_hi;
        mdl_lo = exp_lo;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(15, 0));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        checks_total = 0; checks_passed = 0;
        mdl_hi = '0; mdl_lo = '0;
        div_start_cnt = 0; seen_div_a = '0; seen_div_b = '0;
        stub_delay = 3; stub_hang = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_hi", bus.hi, 32'd0);
        checkOutput("rst_lo", bus.lo, 32'd0);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_done", bus.done, 1'b0);
        checkOutput("rst_flags", {bus.div_zero, bus.div_err, bus.div_start}, 3'b000);
        checkOutput("rst_div_ab", {bus.div_a, bus.div_b}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        applyStimulus(OP_MTHI, 32'hAA, 32'd0);
        applyStimulus(OP_MTLO, 32'hBB, 32'd0);
        applyStimulus(OP_DIV, 32'd5, 32'd0);
        stub_delay = 32;
        applyStimulus(OP_DIV, 32'd7, 32'd2);
        stub_delay = 5;
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        stub_hang = 1'b1;
        applyStimulus(OP_DIV, 32'd9, 32'd3);
        stub_hang = 1'b0;
        applyStimulus(OP_MTLO, 32'h55, 32'd0);

        // Start while busy must be dropped, then reset aborts the multiply.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd1234; bus.b = 32'd5678;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_start_done", bus.done, 1'b0);
        checkOutput("busy_start_hi", bus.hi, mdl_hi);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("abort_ctl", {bus.busy, bus.done, bus.div_zero, bus.div_err, bus.div_start}, 5'd0);
        @(negedge clock);
        reset = 1'b1;
        mdl_hi = '0; mdl_lo = '0;
        seen = 1'b0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) seen = 1'b1;
        end
        checkOutput("abort_no_done", seen, 1'b0);
        checkOutput("abort_hi_kept", bus.hi, 32'd0);

        for (int i = 0; i < 60; i++) begin
            stub_delay = $urandom_range(20, 1);
            applyStimulus(3'($urandom_range(7, 0)), pickOperand(), pickOperand());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
